// File: rtl/fir_out_stage.sv
// FIR output stage: decimate, round/shift, saturate, then queue samples in a small FIFO
// feeding a valid/ready stream. Sticky flags report saturation and FIFO overrun.
module fir_out_stage #(
    parameter int Y_N_SIZE   = 14,
    parameter int OUT_SIZE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [Y_N_SIZE-1:0] y_n,
    input  logic                       in_valid,
    input  logic [2:0]                 shift,
    input  logic [1:0]                 decim,
    input  logic                       clear,
    input  logic                       m_tready,
    output logic                       m_tvalid,
    output logic signed [OUT_SIZE-1:0] m_tdata,
    output logic                       overflow,
    output logic                       drop
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic signed [Y_N_SIZE:0] SAT_HI =
        {{(Y_N_SIZE-OUT_SIZE+2){1'b0}}, {(OUT_SIZE-1){1'b1}}};
    localparam logic signed [Y_N_SIZE:0] SAT_LO =
        {{(Y_N_SIZE-OUT_SIZE+2){1'b1}}, {(OUT_SIZE-1){1'b0}}};

    logic [1:0]                 dcnt, decim_lat, dlim;
    logic                       keep;
    logic                       s1_vld;
    logic signed [Y_N_SIZE-1:0] s1_y;
    logic [2:0]                 s1_sh;

    // A new decimation period starts whenever the counter sits at 0, so the
    // decim value seen at that moment governs the whole period.
    assign keep = in_valid && (dcnt == 2'd0);
    assign dlim = (dcnt == 2'd0) ? decim : decim_lat;

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt      <= 2'd0;
            decim_lat <= 2'd0;
            s1_vld    <= 1'b0;
            s1_y      <= '0;
            s1_sh     <= 3'd0;
        end else begin
            if (in_valid) begin
                if (dcnt == 2'd0)
                    decim_lat <= decim;
                dcnt <= (dcnt == dlim) ? 2'd0 : dcnt + 2'd1;
            end
            s1_vld <= keep;
            if (keep) begin
                s1_y  <= y_n;
                s1_sh <= shift;
            end
        end
    end

    logic signed [Y_N_SIZE:0]   ext, rnd, sum, shifted;
    logic                       sat_hi, sat_lo;
    logic signed [OUT_SIZE-1:0] result;

    always_comb begin
        ext = {s1_y[Y_N_SIZE-1], s1_y};
        rnd = '0;
        if (s1_sh != 3'd0)
            rnd[s1_sh - 3'd1] = 1'b1;
        sum     = ext + rnd;
        shifted = sum >>> s1_sh;
        sat_hi  = shifted > SAT_HI;
        sat_lo  = shifted < SAT_LO;
        if (sat_hi)
            result = SAT_HI[OUT_SIZE-1:0];
        else if (sat_lo)
            result = SAT_LO[OUT_SIZE-1:0];
        else
            result = shifted[OUT_SIZE-1:0];
    end

    logic [OUT_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                pop, wr;

    assign pop = (count != '0) && m_tready;
    // Popping frees a slot in the same edge, so a full FIFO still takes the write.
    assign wr  = s1_vld && ((count != FULL_CNT) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)
                count <= count + 1'b1;
            else if (!wr && pop)
                count <= count - 1'b1;
            if (s1_vld && (sat_hi || sat_lo))
                overflow <= 1'b1;
            else if (clear)
                overflow <= 1'b0;
            if (s1_vld && !wr)
                drop <= 1'b1;
            else if (clear)
                drop <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= result;
    end

    assign m_tvalid = (count != '0);
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_fir_out_stage.sv
// Directed self-checking bench for fir_out_stage: reset, latency/rounding,
// saturation, FIFO full/drop, decimation and mid-operation reset.
module tb_fir_out_stage;
    logic              clk = 1'b0;
    logic              reset;
    logic signed [13:0] y_n;
    logic              in_valid;
    logic [2:0]        shift;
    logic [1:0]        decim;
    logic              clear;
    logic              m_tready;
    logic              m_tvalid;
    logic signed [7:0] m_tdata;
    logic              overflow;
    logic              drop;

    int checks = 0;
    int errors = 0;

    fir_out_stage #(.Y_N_SIZE(14), .OUT_SIZE(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .y_n(y_n), .in_valid(in_valid), .shift(shift),
        .decim(decim), .clear(clear), .m_tready(m_tready), .m_tvalid(m_tvalid),
        .m_tdata(m_tdata), .overflow(overflow), .drop(drop)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; y_n = 14'sd55; shift = 3'd0; decim = 2'd0;
        clear = 1'b0; m_tready = 1'b1;
        tick(); tick();
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'sd0 || overflow !== 1'b0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tvalid=%b tdata=%0d ovf=%b drop=%b, required 0 0 0 0",
                     m_tvalid, m_tdata, overflow, drop);
        end
        in_valid = 1'b0; reset = 1'b0;
        tick(); tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_keep: tvalid=%b, required 0", m_tvalid);
        end
    endtask

    task automatic test_latency();
        y_n = 14'sd100; shift = 3'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1: tvalid=%b, required 0", m_tvalid);
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'sd100) begin
            errors++;
            $display("FAIL latency_c2: tvalid=%b tdata=%0d, required 1 100", m_tvalid, m_tdata);
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_c3: tvalid=%b, required 0", m_tvalid);
        end
    endtask

    task automatic test_rounding();
        y_n = -14'sd7; shift = 3'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== -8'sd2) begin
            errors++;
            $display("FAIL round_neg7: tvalid=%b tdata=%0d, required 1 -2", m_tvalid, m_tdata);
        end
        y_n = 14'sd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'sd2) begin
            errors++;
            $display("FAIL round_pos6: tvalid=%b tdata=%0d, required 1 2", m_tvalid, m_tdata);
        end
        shift = 3'd0;
        tick();
    endtask

    task automatic test_saturation();
        y_n = 14'sd300; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (m_tdata !== 8'sd127 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: tdata=%0d ovf=%b, required 127 1", m_tdata, overflow);
        end
        y_n = -14'sd300; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (m_tdata !== -8'sd128) begin
            errors++;
            $display("FAIL sat_neg: tdata=%0d, required -128", m_tdata);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_fifo();
        m_tready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            y_n = 14'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (drop !== 1'b1 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: drop=%b tvalid=%b, required 1 1", drop, m_tvalid);
        end
        tick();
        checks++;
        if (m_tdata !== 8'sd1) begin
            errors++;
            $display("FAIL full_stable: tdata=%0d, required 1", m_tdata);
        end
        m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 8'(i)) begin
                errors++;
                $display("FAIL full_drain%0d: tvalid=%b tdata=%0d, required 1 %0d",
                         i, m_tvalid, m_tdata, i);
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: tvalid=%b, required 0", m_tvalid);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: drop=%b, required 0", drop);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [7:0] got [$];
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3);
            y_n = 14'(20 + i);
            tick();
            if (m_tvalid) got.push_back(m_tdata);
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 3 || got[0] !== 8'sd20 || got[1] !== 8'sd21 || got[2] !== 8'sd22) begin
            errors++;
            $display("FAIL back_to_back: got %0d samples first=%0d, required 3 samples 20,21,22",
                     got.size(), (got.size() > 0) ? got[0] : 8'sd0);
        end
    endtask

    task automatic test_decimation();
        logic signed [7:0] got [$];
        // 10..14, one idle cycle, 15..18, then drain
        int vals [16] = '{10, 11, 12, 13, 14, -1, 15, 16, 17, 18, -1, -1, -1, -1, -1, -1};
        decim = 2'd2;
        for (int i = 0; i < 16; i++) begin
            in_valid = (vals[i] >= 0);
            y_n = 14'(vals[i]);
            tick();
            if (m_tvalid) got.push_back(m_tdata);
        end
        in_valid = 1'b0;
        decim = 2'd0;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL decim_count: got %0d samples, required 3", got.size());
        end else begin
            checks++;
            if (got[0] !== 8'sd10 || got[1] !== 8'sd13 || got[2] !== 8'sd16) begin
                errors++;
                $display("FAIL decim_values: got %0d,%0d,%0d, required 10,13,16",
                         got[0], got[1], got[2]);
            end
        end
    endtask

    task automatic test_reset_midop();
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            y_n = 14'(7 + i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'sd7) begin
            errors++;
            $display("FAIL midop_fill: tvalid=%b tdata=%0d, required 1 7", m_tvalid, m_tdata);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'sd0) begin
            errors++;
            $display("FAIL midop_reset: tvalid=%b tdata=%0d, required 0 0", m_tvalid, m_tdata);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL midop_ghost%0d: tvalid=%b tdata=%0d, required 0", i, m_tvalid, m_tdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_full_fifo();
        test_back_to_back();
        test_decimation();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_out_stage.md
FIR_OUT_STAGE -- requirements
Module: fir_out_stage

Interface
REQ-001 Parameter Y_N_SIZE, default 14: width of signed FIR result input.
REQ-002 Parameter OUT_SIZE, default 8: width of signed output sample.
REQ-003 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 y_n  input  Y_N_SIZE  signed FIR result.
REQ-007 in_valid  input  1  y_n holds a valid sample this cycle (FIR in ACTIVE).
REQ-008 shift  input  3  right-shift amount 0..7 applied to y_n, sampled with each accepted sample.
REQ-009 decim  input  2  decimation: keep one of every decim+1 valid samples.
REQ-010 clear  input  1  clears sticky flags.
REQ-011 m_tready  input  1  downstream ready.
REQ-012 m_tvalid  output  1  m_tdata valid.
REQ-013 m_tdata  output  OUT_SIZE  signed scaled sample, FIFO head.
REQ-014 overflow  output  1  sticky: a kept sample saturated.
REQ-015 drop  output  1  sticky: a kept sample was lost to a full FIFO.

Function
REQ-016 Decimation counter SHALL advance only on in_valid=1 cycles; sample kept when counter=0; counter wraps to 0 after reaching decim; held while in_valid=0.
REQ-017 decim changes SHALL take effect at the next counter wrap; counter value never exceeds the decim latched at the last wrap.
REQ-018 Stage 1 register SHALL capture y_n and shift for kept samples; non-kept samples produce no stage-1 valid.
REQ-019 Stage 2 SHALL compute (y_n + (shift>0 ? 2^(shift-1) : 0)) >>> shift in Y_N_SIZE+1 bits, arithmetic shift (round half toward +inf).
REQ-020 Result SHALL saturate to [-2^(OUT_SIZE-1), 2^(OUT_SIZE-1)-1]; saturation SHALL set overflow.
REQ-021 Stage 2 result SHALL be written into the FIFO in the same cycle it is computed; latency from in_valid cycle c to m_tvalid=1 with FIFO previously empty SHALL be cycle c+2.
REQ-022 m_tvalid SHALL equal FIFO non-empty; m_tdata SHALL equal FIFO head; pop occurs on rising edge with m_tvalid=1 and m_tready=1.
REQ-023 m_tdata SHALL remain stable while m_tvalid=1 and m_tready=0.
REQ-024 Write with FIFO full and no simultaneous pop SHALL be discarded, FIFO contents unchanged, drop set.
REQ-025 Simultaneous write and pop when full SHALL accept the write; drop not set.
REQ-026 Simultaneous write and pop at count 1 SHALL keep count 1 with new entry at head next cycle.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH distinguishes full from empty.
REQ-028 clear=1 SHALL zero overflow and drop next edge; a set event in the same cycle SHALL win.
REQ-029 m_tready SHALL not influence stages 1-2; no backpressure upstream.

Reset
REQ-030 reset=1 SHALL on the next rising edge zero decimation counter, stage valids, FIFO pointers and count, overflow, drop; m_tvalid=0, m_tdata=0.
REQ-031 reset SHALL override all other inputs mid-operation; in-flight and queued samples discarded.
REQ-032 in_valid during reset cycle SHALL not be kept; first kept sample is the first in_valid after reset deasserts.

Verification
REQ-033 Reset: hold reset 2 cycles with in_valid=1 -> m_tvalid=0, m_tdata=0, overflow=0, drop=0.
REQ-034 Latency/rounding: shift=0, decim=0, y_n=100 in cycle c, m_tready=1 -> m_tvalid=1, m_tdata=100 in cycle c+2 only; shift=2, y_n=-7 -> -2; y_n=6 -> 2.
REQ-035 Saturation: shift=0, y_n=300 -> 127, overflow=1; y_n=-300 -> -128; clear=1 -> overflow=0.
REQ-036 Full FIFO: m_tready=0, decim=0, six consecutive samples 1..6 -> drop=1; then m_tready=1 -> outputs 1,2,3,4 in order, then m_tvalid=0.
REQ-037 Decimation: decim=2, nine consecutive samples 10..18, m_tready=1 -> outputs 10,13,16 only; a gap in in_valid does not shift the pattern.
REQ-038 Reset mid-operation: FIFO holding 3 entries, assert reset 1 cycle -> m_tvalid=0 next cycle, no queued sample reappears.
